// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, bus widths and the arbiter
// state type used by sdram_arbit and sdram_cmd_mux.
package sdram_pkg;

    localparam int SDRAM_CMD_W  = 4;
    localparam int SDRAM_BA_W   = 2;
    localparam int SDRAM_ADDR_W = 13;
    localparam int SDRAM_DQ_W   = 16;

    // Command bits are {cs_n, ras_n, cas_n, we_n}
    localparam logic [SDRAM_CMD_W-1:0] CMD_NOP  = 4'b0111;
    localparam logic [SDRAM_CMD_W-1:0] CMD_ACT  = 4'b0011;
    localparam logic [SDRAM_CMD_W-1:0] CMD_RD   = 4'b0101;
    localparam logic [SDRAM_CMD_W-1:0] CMD_WR   = 4'b0100;
    localparam logic [SDRAM_CMD_W-1:0] CMD_PRE  = 4'b0010;
    localparam logic [SDRAM_CMD_W-1:0] CMD_AREF = 4'b0001;
    localparam logic [SDRAM_CMD_W-1:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        ARBIT = 3'd1,
        AREF  = 3'd2,
        WRITE = 3'd3,
        READ  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// sdram_cmd_mux: combinational selection of the SDRAM command, bank,
// address and write data from the arbiter state. No added latency.
module sdram_cmd_mux
    import sdram_pkg::*;
(
    input  arb_state_t              state,
    input  logic [SDRAM_CMD_W-1:0]  init_cmd,
    input  logic [SDRAM_BA_W-1:0]   init_ba,
    input  logic [SDRAM_ADDR_W-1:0] init_addr,
    input  logic [SDRAM_CMD_W-1:0]  aref_cmd,
    input  logic [SDRAM_BA_W-1:0]   aref_ba,
    input  logic [SDRAM_ADDR_W-1:0] aref_addr,
    input  logic [SDRAM_CMD_W-1:0]  wr_cmd,
    input  logic [SDRAM_BA_W-1:0]   wr_ba,
    input  logic [SDRAM_ADDR_W-1:0] wr_addr,
    input  logic [SDRAM_DQ_W-1:0]   wr_data,
    input  logic [SDRAM_CMD_W-1:0]  rd_cmd,
    input  logic [SDRAM_BA_W-1:0]   rd_ba,
    input  logic [SDRAM_ADDR_W-1:0] rd_addr,
    output logic [SDRAM_CMD_W-1:0]  cmd,
    output logic [SDRAM_BA_W-1:0]   ba,
    output logic [SDRAM_ADDR_W-1:0] addr,
    output logic [SDRAM_DQ_W-1:0]   dq_out,
    output logic                    dq_oe
);

    // Forward the owning sequencer's command; NOP while arbitrating
    always_comb begin
        cmd    = CMD_NOP;
        ba     = '0;
        addr   = '0;
        dq_out = '0;
        dq_oe  = 1'b0;
        case (state)
            INIT: begin
                cmd  = init_cmd;
                ba   = init_ba;
                addr = init_addr;
            end
            AREF: begin
                cmd  = aref_cmd;
                ba   = aref_ba;
                addr = aref_addr;
            end
            WRITE: begin
                cmd    = wr_cmd;
                ba     = wr_ba;
                addr   = wr_addr;
                dq_out = wr_data;
                dq_oe  = 1'b1;
            end
            READ: begin
                cmd  = rd_cmd;
                ba   = rd_ba;
                addr = rd_addr;
            end
            default: begin
                cmd  = CMD_NOP;
                ba   = '0;
                addr = '0;
            end
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: grants the SDRAM bus to the init, refresh, write and read
// sequencers. Refresh has fixed top priority. Optional macro
// SDRAM_ARBIT_RR_EN alternates write/read when both are pending;
// otherwise write always beats read.
module sdram_arbit
    import sdram_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    init_end,
    input  logic [SDRAM_CMD_W-1:0]  init_cmd,
    input  logic [SDRAM_BA_W-1:0]   init_ba,
    input  logic [SDRAM_ADDR_W-1:0] init_addr,
    input  logic                    aref_req,
    input  logic                    aref_end,
    input  logic [SDRAM_CMD_W-1:0]  aref_cmd,
    input  logic [SDRAM_BA_W-1:0]   aref_ba,
    input  logic [SDRAM_ADDR_W-1:0] aref_addr,
    input  logic                    wr_req,
    input  logic                    wr_end,
    input  logic [SDRAM_CMD_W-1:0]  wr_cmd,
    input  logic [SDRAM_BA_W-1:0]   wr_ba,
    input  logic [SDRAM_ADDR_W-1:0] wr_addr,
    input  logic [SDRAM_DQ_W-1:0]   wr_data,
    input  logic                    rd_req,
    input  logic                    rd_end,
    input  logic [SDRAM_CMD_W-1:0]  rd_cmd,
    input  logic [SDRAM_BA_W-1:0]   rd_ba,
    input  logic [SDRAM_ADDR_W-1:0] rd_addr,
    output logic                    aref_en,
    output logic                    wr_en,
    output logic                    rd_en,
    output logic                    sdram_cke,
    output logic                    sdram_cs_n,
    output logic                    sdram_ras_n,
    output logic                    sdram_cas_n,
    output logic                    sdram_we_n,
    output logic [SDRAM_BA_W-1:0]   sdram_ba,
    output logic [SDRAM_ADDR_W-1:0] sdram_addr,
    output logic [SDRAM_DQ_W-1:0]   sdram_dq_out,
    output logic                    sdram_dq_oe
);

    arb_state_t             state;
    logic [SDRAM_CMD_W-1:0] cmd;
    logic                   pick_rd;

`ifdef SDRAM_ARBIT_RR_EN
    logic last_wr;

    // Read wins a write/read tie only when the previous grant was a write
    always_comb begin
        pick_rd = ~wr_req | (rd_req & last_wr);
    end

    // Remember whether the latest write/read grant was a write
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            last_wr <= 1'b0;
        end else if (state == ARBIT && !aref_req && (wr_req || rd_req)) begin
            last_wr <= ~pick_rd;
        end
    end
`else
    // Write always beats read when both are pending
    always_comb begin
        pick_rd = ~wr_req;
    end
`endif

    // Grant FSM: state and registered grants move on the same edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state   <= INIT;
            aref_en <= 1'b0;
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_end) begin
                        state <= ARBIT;
                    end
                end
                ARBIT: begin
                    if (aref_req) begin
                        state   <= AREF;
                        aref_en <= 1'b1;
                    end else if (wr_req && !pick_rd) begin
                        state <= WRITE;
                        wr_en <= 1'b1;
                    end else if (rd_req) begin
                        state <= READ;
                        rd_en <= 1'b1;
                    end
                end
                AREF: begin
                    if (aref_end) begin
                        state   <= ARBIT;
                        aref_en <= 1'b0;
                    end
                end
                WRITE: begin
                    if (wr_end) begin
                        state <= ARBIT;
                        wr_en <= 1'b0;
                    end
                end
                READ: begin
                    if (rd_end) begin
                        state <= ARBIT;
                        rd_en <= 1'b0;
                    end
                end
                default: begin
                    state   <= INIT;
                    aref_en <= 1'b0;
                    wr_en   <= 1'b0;
                    rd_en   <= 1'b0;
                end
            endcase
        end
    end

    sdram_cmd_mux u_cmd_mux (
        .state     (state),
        .init_cmd  (init_cmd),
        .init_ba   (init_ba),
        .init_addr (init_addr),
        .aref_cmd  (aref_cmd),
        .aref_ba   (aref_ba),
        .aref_addr (aref_addr),
        .wr_cmd    (wr_cmd),
        .wr_ba     (wr_ba),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_cmd    (rd_cmd),
        .rd_ba     (rd_ba),
        .rd_addr   (rd_addr),
        .cmd       (cmd),
        .ba        (sdram_ba),
        .addr      (sdram_addr),
        .dq_out    (sdram_dq_out),
        .dq_oe     (sdram_dq_oe)
    );

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;

endmodule
